signal_monitor: RTL and testbench
=================================

# signal_monitor

Parametrised multi-channel signal analyser for the lab sequential-logic set. It samples `CHANNELS` synchronous digital inputs over a programmable window of clock cycles. Per channel, it counts rising edges, falling edges, both edges, or high-level cycles, using saturating counters with sticky overflow flags. Results are held after completion and read through a channel-select mux, so one instance replaces per-signal flip-flop probes in analysis benches.

## Interface
- `CHANNELS`, 4: number of monitored inputs (≥1)
- `CNT_W`, 8: per-channel counter width
- `WIN_W`, 8: width of the window-length input
- `CH_W`, derived, max(1, clog2(CHANNELS)): select width

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `din`  in  CHANNELS  monitored signals, synchronous to `clk`
- `mode`  in  2  00 rising, 01 falling, 10 both edges, 11 high-level cycles
- `window`  in  WIN_W  measurement length in cycles; sampled at start
- `start`  in  1  request measurement (level sampled each edge)
- `rd_sel`  in  CH_W  channel to present on `rd_count`/`rd_ovf`
- `busy`  out  1  high while not IDLE
- `done`  out  1  one-cycle completion pulse
- `rd_count`  out  CNT_W  result of channel `rd_sel`; combinational mux of result registers
- `rd_ovf`  out  1  overflow flag of channel `rd_sel`
- `ovf`  out  CHANNELS  sticky per-channel overflow flags

## Operation
- FSM states: IDLE, MEASURE, DONE. Encoding is free.
- IDLE, with `start`=1 and `window`≠0:
  - latch `mode` and `window`
  - clear all counters and `ovf`
  - set `prev` to `din`
  - load remaining = `window`
  - go to MEASURE
- IDLE, with `start`=1 and `window`=0: ignored; stay in IDLE, no `done`.
- MEASURE, each cycle:
  - Per channel, event = rise (`din` & ~`prev`), fall (~`din` & `prev`), rise|fall, or `din`, according to the latched mode.
  - On an event, the counter increments. At all-ones it holds, and that channel's `ovf` bit sets.
  - `prev` ← `din`; remaining decrements.
  - When remaining = 1, go to DONE. Exactly `window` samples are taken.
- DONE: `done`=1 for this single cycle, then go to IDLE.
- `start`, `mode` and `window` are ignored while `busy`. The latched copies govern the whole run.
- Counters and `ovf` hold their values from DONE until the next accepted start or reset.
- `rd_sel` ≥ `CHANNELS`: `rd_count`=0, `rd_ovf`=0.
- Counters are unsigned. Increment is width-exact with no wrap-around; saturation replaces wrap.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `ovf`=0, all counters 0, `rd_count`=0, `rd_ovf`=0
  - `prev`=0, latched mode 00
- Start accepted at edge T:
  - `busy` high from after T.
  - Samples are taken at edges T+1 … T+W.
  - `done` is high between edges T+W and T+W+1.
  - `busy` falls after edge T+W+1.
- Next start is accepted at the earliest at edge T+W+2. A `start` asserted at edge T+W+1 (DONE) is ignored.
- An edge between the start-cycle sample (edge T) and the first measure sample (edge T+1) counts.
- Reset asserted mid-MEASURE or in DONE:
  - Immediate return to reset values, no `done` pulse.
  - Partial counts are discarded.
- `rd_count` follows `rd_sel` in the same cycle, with zero latency.

## Test plan
Test configuration: CHANNELS=4, CNT_W=4, WIN_W=8.
- Reset check: assert `reset` asynchronously mid-cycle with random inputs -> all outputs 0 immediately. Hold 3 cycles with `start`=1 -> `busy` stays 0.
- Edge modes: `din[0]`=0 at start, then toggles every cycle, `window`=8.
  - mode 00 -> `rd_count`[0]=4; mode 01 -> 4; mode 10 -> 8.
  - Each run: `done` pulse exactly 8 cycles after the start edge, `ovf`=0.
- Level mode: mode 11, `window`=10, `din[1]`=1, `din[2]`=0 -> counts 10 and 0, `ovf`=0000.
- Saturation: mode 11, `din[3]`=1, `window`=20 -> count[3]=15, `ovf`=1000, `rd_ovf`=1 with `rd_sel`=3. `rd_sel`=0 shows 0.
- Ignored requests:
  - `start` with `window`=0 -> no `busy`, no `done`.
  - `start` re-pulsed and `mode` changed mid-run -> run length and mode unchanged, a single `done`.
  - `start` during DONE -> ignored.
- Reset mid-measure: `window`=8, `reset` at sample 3 -> counts 0, `busy`=0, no `done`. A fresh start then completes normally with correct counts.

Source files
------------

// File: rtl/signal_monitor.sv
// Multi-channel edge/level event counter over a programmable sample window.
// Saturating per-channel counters with sticky overflow, read back through a channel-select mux.
module signal_monitor #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8,
   parameter int WIN_W    = 8,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] din,
   input  logic [1:0]          mode,
   input  logic [WIN_W-1:0]    window,
   input  logic                start,
   input  logic [CH_W-1:0]     rd_sel,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    rd_count,
   output logic                rd_ovf,
   output logic [CHANNELS-1:0] ovf
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_mode;
   logic [WIN_W-1:0]     r_remain;
   logic [CHANNELS-1:0]  r_prev;
   logic [CHANNELS-1:0]  r_ovf;
   logic [CNT_W-1:0]     r_cnt [CHANNELS];

   logic                 w_accept;
   logic [CHANNELS-1:0]  w_rise;
   logic [CHANNELS-1:0]  w_fall;
   logic [CHANNELS-1:0]  w_evt;

   assign w_accept = (r_state == S_IDLE) && start && (window != '0);
   assign w_rise   = din & ~r_prev;
   assign w_fall   = ~din & r_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = S_MEASURE;
         S_MEASURE: if (r_remain == WIN_W'(1)) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   always_comb begin
      w_evt = '0;
      case (r_mode)
         2'b00:   w_evt = w_rise;
         2'b01:   w_evt = w_fall;
         2'b10:   w_evt = w_rise | w_fall;
         default: w_evt = din;
      endcase
   end

   // Overflow flags on an event that arrives while the counter already sits at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode   <= 2'b00;
         r_remain <= '0;
         r_prev   <= '0;
         r_ovf    <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (w_accept) begin
         r_mode   <= mode;
         r_remain <= window;
         r_prev   <= din;
         r_ovf    <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (r_state == S_MEASURE) begin
         r_prev   <= din;
         r_remain <= r_remain - 1'b1;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_evt[i]) begin
               if (r_cnt[i] == '1) begin
                  r_ovf[i] <= 1'b1;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      rd_count = '0;
      rd_ovf   = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (rd_sel == i[CH_W-1:0]) begin
            rd_count = r_cnt[i];
            rd_ovf   = r_ovf[i];
         end
      end
   end

   assign ovf = r_ovf;

endmodule

// File: tb/tb_signal_monitor.sv
// Directed bench for signal_monitor (CHANNELS=4, CNT_W=4, WIN_W=8).
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
module tb_signal_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] din;
   logic [1:0] mode;
   logic [7:0] window;
   logic       start;
   logic [1:0] rd_sel;
   logic       busy;
   logic       done;
   logic [3:0] rd_count;
   logic       rd_ovf;
   logic [3:0] ovf;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   signal_monitor #(
      .CHANNELS(4),
      .CNT_W   (4),
      .WIN_W   (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .din     (din),
      .mode    (mode),
      .window  (window),
      .start   (start),
      .rd_sel  (rd_sel),
      .busy    (busy),
      .done    (done),
      .rd_count(rd_count),
      .rd_ovf  (rd_ovf),
      .ovf     (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] m, input logic [7:0] w, input logic [3:0] d);
      din    = d;
      mode   = m;
      window = w;
      start  = 1'b1;
      step();
      start  = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
      chk("done_after_start", 32'(done), 0);
   endtask

   // Step w sample edges; din[0] alternates 1,0,1,... when tog is set.
   task automatic run_cycles(input int w, input bit tog);
      for (int k = 1; k <= w; k++) begin
         if (tog) din[0] = k[0];
         step();
         chk("done_timing", 32'(done), (k == w) ? 1 : 0);
      end
   endtask

   task automatic finish_run();
      step();
      chk("busy_back_idle", 32'(busy), 0);
      chk("done_back_idle", 32'(done), 0);
   endtask

   initial begin
      reset  = 1'b1;
      din    = 4'($urandom);
      mode   = 2'($urandom);
      window = 8'($urandom);
      start  = 1'($urandom);
      rd_sel = 2'($urandom);
      #2;
      chk("rst_busy",     32'(busy),     0);
      chk("rst_done",     32'(done),     0);
      chk("rst_ovf",      32'(ovf),      0);
      chk("rst_rd_count", 32'(rd_count), 0);
      chk("rst_rd_ovf",   32'(rd_ovf),   0);
      start  = 1'b1;
      window = 8'd5;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_hold_busy", 32'(busy), 0);
      end
      reset  = 1'b0;
      start  = 1'b0;
      din    = 4'b0000;
      mode   = 2'b00;
      window = 8'd0;
      rd_sel = 2'd0;
      step();
      chk("idle_busy", 32'(busy), 0);

      // Edge modes on a toggling din[0]
      launch(2'b00, 8'd8, 4'b0000);
      run_cycles(8, 1'b1);
      chk("rise_count", 32'(rd_count), 4);
      chk("rise_ovf",   32'(ovf),      0);
      finish_run();
      launch(2'b01, 8'd8, 4'b0000);
      run_cycles(8, 1'b1);
      chk("fall_count", 32'(rd_count), 4);
      chk("fall_ovf",   32'(ovf),      0);
      finish_run();
      launch(2'b10, 8'd8, 4'b0000);
      run_cycles(8, 1'b1);
      chk("both_count", 32'(rd_count), 8);
      chk("both_ovf",   32'(ovf),      0);
      finish_run();

      // Level mode
      launch(2'b11, 8'd10, 4'b0010);
      run_cycles(10, 1'b0);
      rd_sel = 2'd1;
      #1;
      chk("level_ch1", 32'(rd_count), 10);
      rd_sel = 2'd2;
      #1;
      chk("level_ch2", 32'(rd_count), 0);
      chk("level_ovf", 32'(ovf),      0);
      finish_run();

      // Saturation
      launch(2'b11, 8'd20, 4'b1000);
      run_cycles(20, 1'b0);
      rd_sel = 2'd3;
      #1;
      chk("sat_count",  32'(rd_count), 15);
      chk("sat_rd_ovf", 32'(rd_ovf),   1);
      chk("sat_ovf",    32'(ovf),      4'b1000);
      rd_sel = 2'd0;
      #1;
      chk("sat_ch0_count",  32'(rd_count), 0);
      chk("sat_ch0_rd_ovf", 32'(rd_ovf),   0);
      finish_run();
      din = 4'b0000;

      // start with window 0 is ignored
      start  = 1'b1;
      window = 8'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("win0_busy", 32'(busy), 0);
         chk("win0_done", 32'(done), 0);
      end
      start = 1'b0;

      // Re-pulsed start and mode change mid-run, then start during DONE
      launch(2'b00, 8'd8, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
         din[0] = k[0];
         if (k == 3) begin
            start  = 1'b1;
            mode   = 2'b10;
            window = 8'd3;
         end
         if (k == 6) start = 1'b0;
         step();
         chk("repulse_done", 32'(done), (k == 8) ? 1 : 0);
      end
      chk("repulse_count", 32'(rd_count), 4);
      start  = 1'b1;
      window = 8'd5;
      mode   = 2'b11;
      step();
      start  = 1'b0;
      chk("start_in_done_busy", 32'(busy), 0);
      chk("start_in_done_done", 32'(done), 0);
      step();
      chk("start_in_done_busy2", 32'(busy),     0);
      chk("held_count",          32'(rd_count), 4);

      // Reset mid-measure
      launch(2'b00, 8'd8, 4'b0000);
      for (int k = 1; k <= 3; k++) begin
         din[0] = k[0];
         step();
      end
      chk("partial_count", 32'(rd_count), 2);
      reset = 1'b1;
      #1;
      chk("midrst_busy",  32'(busy),     0);
      chk("midrst_done",  32'(done),     0);
      chk("midrst_count", 32'(rd_count), 0);
      chk("midrst_ovf",   32'(ovf),      0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("post_rst_busy", 32'(busy), 0);
         chk("post_rst_done", 32'(done), 0);
      end
      launch(2'b10, 8'd8, 4'b0000);
      run_cycles(8, 1'b1);
      chk("fresh_count", 32'(rd_count), 8);
      chk("fresh_ovf",   32'(ovf),      0);
      finish_run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
